flit_link_tx: RTL and testbench

Credit-based flit transmitter for one router-to-router link. It accepts flits from a local valid/ready source, buffers them in a 2-entry skid FIFO, and drives `send_out`/`data_out`/`dest_out`/`is_tail_out` toward a downstream router input port. A credit counter is sized to that port's `FLIT_BUFFER_DEPTH` and replenished by `credit_in`, so the downstream buffer can never overflow. The block sits between any flit producer and the credit-flow-controlled router link.

---
 rtl/flit_link_tx.sv | 119 +++++++++++
 tb/tb_flit_link_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/flit_link_tx.sv
// Credit-based flit transmitter: 2-entry skid FIFO feeding a registered link port.
// Define FLIT_LINK_TX_CREDIT_CHECK_EN to add the sticky credit_err overflow flag.
module flit_link_tx #(
    parameter int FLIT_WIDTH   = 64,
    parameter int DEST_WIDTH   = 4,
    parameter int CREDIT_COUNT = 8,
    parameter int CNT_WIDTH    = $clog2(CREDIT_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLIT_WIDTH-1:0] in_data,
    input  logic [DEST_WIDTH-1:0] in_dest,
    input  logic                  in_is_tail,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic [CNT_WIDTH-1:0]  credits_avail,
    output logic                  pkt_active
`ifdef FLIT_LINK_TX_CREDIT_CHECK_EN
    ,
    output logic                  credit_err
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CREDIT_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [FLIT_WIDTH-1:0] mem_data [2];
    logic [DEST_WIDTH-1:0] mem_dest [2];
    logic [1:0]            mem_tail;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  credit_max;

    // Source handshake: a flit transfers on a clock edge where in_valid && in_ready;
    // the source holds its flit stable until then, and in_ready never depends on in_valid.
    assign full       = (occ == 2'd2);
    assign empty      = (occ == 2'd0);
    assign in_ready   = !rst && !full;
    assign push       = in_valid && in_ready;
    assign pop        = !empty && (credits_avail != '0);
    assign credit_max = (credits_avail == CNT_MAX);

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_dest[wr_ptr] <= in_dest;
            mem_tail[wr_ptr] <= in_is_tail;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // A pop always has a credit to spend; a return at full count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_avail <= CNT_MAX;
        end else begin
            case ({pop, credit_in})
                2'b10:   credits_avail <= credits_avail - CNT_ONE;
                2'b01:   if (!credit_max) credits_avail <= credits_avail + CNT_ONE;
                default: credits_avail <= credits_avail;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            send_out    <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
            pkt_active  <= 1'b0;
        end else begin
            send_out <= pop;
            if (pop) begin
                data_out    <= mem_data[rd_ptr];
                dest_out    <= mem_dest[rd_ptr];
                is_tail_out <= mem_tail[rd_ptr];
                pkt_active  <= !mem_tail[rd_ptr];
            end
        end
    end

`ifdef FLIT_LINK_TX_CREDIT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_err <= 1'b0;
        end else if (credit_in && credit_max && !pop) begin
            credit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_flit_link_tx.sv
// Self-checking bench for flit_link_tx: directed scenarios plus random traffic
// against a queue-based reference model of the link transmitter.
module tb_flit_link_tx;

    localparam int FW  = 64;
    localparam int DW  = 4;
    localparam int CC  = 8;
    localparam int CW  = $clog2(CC + 1);
    localparam int W   = FW + DW + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_data;
    logic [DW-1:0] in_dest;
    logic          in_is_tail;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in;
    logic [CW-1:0] credits_avail;
    logic          pkt_active;
`ifdef FLIT_LINK_TX_CREDIT_CHECK_EN
    logic          credit_err;
`endif

    flit_link_tx #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .CREDIT_COUNT(CC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .in_is_tail(in_is_tail),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in),
        .credits_avail(credits_avail), .pkt_active(pkt_active)
`ifdef FLIT_LINK_TX_CREDIT_CHECK_EN
        , .credit_err(credit_err)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = !clk;

    // reference model state
    logic [W-1:0] exp_q[$];   // flits accepted but not yet sent, {tail, dest, data}
    int           m_cred;
    logic         m_send;
    logic [FW-1:0] m_data;
    logic [DW-1:0] m_dest;
    logic         m_tail;
    logic         m_pkt;
    logic         m_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cred = CC;
        m_send = 1'b0;
        m_data = '0;
        m_dest = '0;
        m_tail = 1'b0;
        m_pkt  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs(input logic exp_ready);
        check("in_ready", in_ready, exp_ready);
        check("send_out", send_out, m_send);
        check("data_out", data_out, m_data);
        check("dest_out", dest_out, m_dest);
        check("is_tail_out", is_tail_out, m_tail);
        check("credits_avail", credits_avail, m_cred);
        check("pkt_active", pkt_active, m_pkt);
`ifdef FLIT_LINK_TX_CREDIT_CHECK_EN
        check("credit_err", credit_err, m_err);
`endif
        if (send_out === 1'b1) pulses++;
    endtask

    // Called at a negedge: drive inputs, check, advance the model one clock.
    task automatic step(input logic v, input logic [FW-1:0] d, input logic [DW-1:0] de,
                        input logic t, input logic c);
        logic         push;
        logic         pop;
        logic [W-1:0] f;
        in_valid   = v;
        in_data    = d;
        in_dest    = de;
        in_is_tail = t;
        credit_in  = c;
        #1;
        check_outputs(exp_q.size() < 2);
        push = v && (exp_q.size() < 2);
        pop  = (exp_q.size() != 0) && (m_cred > 0);
        m_send = pop;
        if (pop) begin
            f = exp_q.pop_front();
            {m_tail, m_dest, m_data} = f;
            m_pkt = !m_tail;
        end
        if (pop && !c) m_cred--;
        else if (!pop && c) begin
            if (m_cred == CC) m_err = 1'b1;
            else m_cred++;
        end
        if (push) exp_q.push_back({t, de, d});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Called at a negedge: assert reset asynchronously, hold it, release.
    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        credit_in = 1'b0;
        model_reset();
        #1;
        check_outputs(1'b0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check_outputs(1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
    endtask

    function automatic logic [FW-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_dest = '0;
        in_is_tail = 1'b0;
        credit_in = 1'b0;
        model_reset();
        @(negedge clk);

        // reset values and in_ready rising right after release
        do_reset(2);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("reset_credits", credits_avail, 8);

        // 3-flit packet to dest 5, no credit return
        step(1'b1, 64'h1111, 4'd5, 1'b0, 1'b0);
        step(1'b1, 64'h2222, 4'd5, 1'b0, 1'b0);
        step(1'b1, 64'h3333, 4'd5, 1'b1, 1'b0);
        idle(4);
        check("pkt3_pulses", pulses, 3);
        check("pkt3_credits", credits_avail, 5);
        check("pkt3_pkt_active", pkt_active, 1'b0);

        // exhaust credits: 12 offered flits, only 8 may leave
        @(negedge clk);
        do_reset(1);
        for (int i = 0; i < 12; i++) step(1'b1, rnd_data(), 4'(i), 1'b0, 1'b0);
        idle(3);
        check("starve_pulses", pulses, 8);
        check("starve_credits", credits_avail, 0);
        check("starve_in_ready", in_ready, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle(4);
        check("one_credit_pulses", pulses, 9);

        // steady stream with a credit returned every cycle
        do_reset(1);
        for (int i = 0; i < 20; i++) step(1'b1, rnd_data(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
        check("steady_credits", credits_avail, 8);
        check("steady_send", send_out, 1'b1);
        idle(3);

        // credit return at full count saturates (and flags, when enabled)
        do_reset(1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle(4);
        check("sat_credits", credits_avail, 8);
`ifdef FLIT_LINK_TX_CREDIT_CHECK_EN
        check("sat_err_sticky", credit_err, 1'b1);
`endif

        // reset in the middle of a stream
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b1, rnd_data(), 4'd3, 1'b0, 1'b0);
        do_reset(2);
        idle(4);
        check("midrst_pulses", pulses, 0);
        check("midrst_credits", credits_avail, 8);
        check("midrst_in_ready", in_ready, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) < 7), rnd_data(), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
